// File: rtl/hls_frame_sequencer_if.sv
// Signal bundle between the frame sequencer, its sample/result streams and the hls4ml core.
// The slave modport is the sequencer's view; master is the surrounding environment.
interface hls_frame_sequencer_if #(
    parameter int SAMPLE_W  = 18,
    parameter int N_SAMPLES = 100,
    parameter int OUT_W     = 24,
    parameter int N_OUT     = 2
);
    localparam int CLS_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    logic [SAMPLE_W-1:0]           s_data;
    logic                          s_valid;
    logic                          s_ready;
    logic                          core_start;
    logic                          core_ready;
    logic                          core_done;
    logic                          core_idle;
    logic [N_SAMPLES*SAMPLE_W-1:0] core_in;
    logic                          core_in_vld;
    logic [N_OUT*OUT_W-1:0]        core_out;
    logic [N_OUT-1:0]              core_out_vld;
    logic [N_OUT*OUT_W-1:0]        m_scores;
    logic [CLS_W-1:0]              m_class;
    logic                          m_valid;
    logic                          m_ready;
    logic                          timeout_err;
    logic [15:0]                   frame_cnt;

    modport slave (
        input  s_data, s_valid, core_ready, core_done, core_idle, core_out, core_out_vld, m_ready,
        output s_ready, core_start, core_in, core_in_vld, m_scores, m_class, m_valid,
               timeout_err, frame_cnt
    );

    modport master (
        output s_data, s_valid, core_ready, core_done, core_idle, core_out, core_out_vld, m_ready,
        input  s_ready, core_start, core_in, core_in_vld, m_scores, m_class, m_valid,
               timeout_err, frame_cnt
    );
endinterface

// File: rtl/hls_frame_sequencer.sv
// Packs serial samples into an hls4ml core input, runs the core with timeout recovery,
// captures per-output scores and streams them out with a sequential signed argmax.
module hls_frame_sequencer #(
    parameter int SAMPLE_W  = 18,
    parameter int N_SAMPLES = 100,
    parameter int OUT_W     = 24,
    parameter int N_OUT     = 2,
    parameter int TIMEOUT   = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    hls_frame_sequencer_if.slave   bus
);
    localparam int CLS_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int IDX_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
    localparam int TMO_W = $clog2(TIMEOUT) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);
    localparam logic [CLS_W-1:0] LAST_CLS = CLS_W'(N_OUT - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_FILL    = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_WAIT    = 3'd2,
        ST_ARGMAX  = 3'd3,
        ST_PRESENT = 3'd4
    } state_t;

    state_t                        state_r, state_next_s;
    logic [IDX_W-1:0]              idx_r;
    logic [N_SAMPLES*SAMPLE_W-1:0] core_in_r;
    logic [N_OUT*OUT_W-1:0]        scores_r;
    logic [N_OUT-1:0]              got_r;
    logic                          done_r;
    logic [TMO_W-1:0]              tmo_cnt_r;
    logic [CLS_W-1:0]              best_idx_r, cmp_k_r;
    logic                          s_ready_r, core_start_r, core_in_vld_r, m_valid_r, timeout_err_r;
    logic [15:0]                   frame_cnt_r;

    logic in_core_s, cap_en_s, got_all_s, done_any_s, tmo_hit_s;
    logic accept_s, handoff_s, abort_s, cmp_gt_s;

    function automatic logic signed [OUT_W-1:0] score_at(input logic [N_OUT*OUT_W-1:0] v,
                                                         input logic [CLS_W-1:0] k);
        return v[int'(k)*OUT_W +: OUT_W];
    endfunction

    // Next-state decode plus the qualifiers shared by the datapath blocks.
    always_comb begin
        state_next_s = state_r;
        in_core_s    = (state_r == ST_LAUNCH) || (state_r == ST_WAIT);
        cap_en_s     = ((state_r == ST_LAUNCH) && bus.core_ready) || (state_r == ST_WAIT);
        got_all_s    = &(got_r | (bus.core_out_vld & {N_OUT{cap_en_s}}));
        done_any_s   = done_r | (cap_en_s & bus.core_done);
        tmo_hit_s    = in_core_s && (tmo_cnt_r == TMO_LAST);
        accept_s     = (state_r == ST_FILL) && bus.s_valid;
        handoff_s    = (state_r == ST_PRESENT) && bus.m_ready;
        cmp_gt_s     = score_at(scores_r, cmp_k_r) > score_at(scores_r, best_idx_r);
        case (state_r)
            ST_FILL:    if (accept_s && (idx_r == LAST_IDX)) state_next_s = ST_LAUNCH;
                        else state_next_s = ST_FILL;
            ST_LAUNCH:  if (bus.core_ready) state_next_s = ST_WAIT;
                        else if (tmo_hit_s) state_next_s = ST_FILL;
                        else state_next_s = ST_LAUNCH;
            ST_WAIT:    if (got_all_s && done_any_s) state_next_s = ST_ARGMAX;
                        else if (tmo_hit_s) state_next_s = ST_FILL;
                        else state_next_s = ST_WAIT;
            ST_ARGMAX:  if (cmp_k_r == LAST_CLS) state_next_s = ST_PRESENT;
                        else state_next_s = ST_ARGMAX;
            ST_PRESENT: if (bus.m_ready) state_next_s = ST_FILL;
                        else state_next_s = ST_PRESENT;
            default:    state_next_s = ST_FILL;
        endcase
        abort_s = tmo_hit_s && (state_next_s == ST_FILL);
    end

    // State register and handshake outputs, registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= ST_FILL;
            s_ready_r     <= 1'b1;
            core_start_r  <= 1'b0;
            core_in_vld_r <= 1'b0;
            m_valid_r     <= 1'b0;
            timeout_err_r <= 1'b0;
            frame_cnt_r   <= 16'd0;
            tmo_cnt_r     <= '0;
        end else begin
            state_r       <= state_next_s;
            s_ready_r     <= (state_next_s == ST_FILL);
            core_start_r  <= (state_next_s == ST_LAUNCH);
            core_in_vld_r <= (state_next_s == ST_LAUNCH);
            m_valid_r     <= (state_next_s == ST_PRESENT);
            timeout_err_r <= timeout_err_r | abort_s;
            frame_cnt_r   <= handoff_s ? frame_cnt_r + 16'd1 : frame_cnt_r;
            tmo_cnt_r     <= in_core_s ? tmo_cnt_r + TMO_W'(1) : '0;
        end
    end

    // Sample packing into the core input bus.
    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_r     <= '0;
            core_in_r <= '0;
        end else if (accept_s) begin
            core_in_r[int'(idx_r)*SAMPLE_W +: SAMPLE_W] <= bus.s_data;
            idx_r <= (idx_r == LAST_IDX) ? '0 : idx_r + IDX_W'(1);
        end else begin
            idx_r <= idx_r;
        end
    end

    // Result capture; clearing the flags on handoff or abort wins over a late strobe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            scores_r <= '0;
            got_r    <= '0;
            done_r   <= 1'b0;
        end else begin
            for (int k = 0; k < N_OUT; k++) begin
                if (cap_en_s && bus.core_out_vld[k]) begin
                    scores_r[k*OUT_W +: OUT_W] <= bus.core_out[k*OUT_W +: OUT_W];
                end
            end
            if (handoff_s || abort_s) begin
                got_r  <= '0;
                done_r <= 1'b0;
            end else begin
                got_r  <= got_r | (bus.core_out_vld & {N_OUT{cap_en_s}});
                done_r <= done_any_s;
            end
        end
    end

    // Sequential argmax: strict greater-than keeps the lowest index on ties.
    always_ff @(posedge clk) begin
        if (!rst) begin
            best_idx_r <= '0;
            cmp_k_r    <= '0;
        end else if ((state_r == ST_WAIT) && (state_next_s == ST_ARGMAX)) begin
            best_idx_r <= '0;
            cmp_k_r    <= CLS_W'(1);
        end else if (state_r == ST_ARGMAX) begin
            best_idx_r <= cmp_gt_s ? cmp_k_r : best_idx_r;
            cmp_k_r    <= (cmp_k_r == LAST_CLS) ? cmp_k_r : cmp_k_r + CLS_W'(1);
        end else begin
            best_idx_r <= best_idx_r;
        end
    end

    assign bus.s_ready     = s_ready_r;
    assign bus.core_start  = core_start_r;
    assign bus.core_in     = core_in_r;
    assign bus.core_in_vld = core_in_vld_r;
    assign bus.m_scores    = scores_r;
    assign bus.m_class     = best_idx_r;
    assign bus.m_valid     = m_valid_r;
    assign bus.timeout_err = timeout_err_r;
    assign bus.frame_cnt   = frame_cnt_r;
endmodule

// File: tb/tb_hls_frame_sequencer.sv
// Directed bench for hls_frame_sequencer: frames, argmax corners, backpressure, timeout, reset.
module tb_hls_frame_sequencer;
    localparam int SAMPLE_W  = 18;
    localparam int N_SAMPLES = 100;
    localparam int OUT_W     = 24;
    localparam int N_OUT     = 2;
    localparam int TIMEOUT   = 4096;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    hls_frame_sequencer_if #(.SAMPLE_W(SAMPLE_W), .N_SAMPLES(N_SAMPLES), .OUT_W(OUT_W), .N_OUT(N_OUT)) bus ();

    hls_frame_sequencer #(.SAMPLE_W(SAMPLE_W), .N_SAMPLES(N_SAMPLES), .OUT_W(OUT_W),
                          .N_OUT(N_OUT), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [SAMPLE_W-1:0] base, input int count);
        check("s_ready_fill", 64'(bus.s_ready), 64'd1);
        for (int i = 0; i < count; i++) begin
            bus.s_data  = base + SAMPLE_W'(i);
            bus.s_valid = 1'b1;
            @(negedge clk);
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic launch(input bit give_ready);
        int n = 0;
        while (bus.core_start !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("start_seen", 64'(bus.core_start), 64'd1);
        check("in_vld", 64'(bus.core_in_vld), 64'd1);
        check("s_ready_busy", 64'(bus.s_ready), 64'd0);
        if (give_ready) begin
            bus.core_ready = 1'b1;
            @(negedge clk);
            bus.core_ready = 1'b0;
            check("start_drop", 64'(bus.core_start), 64'd0);
        end
    endtask

    task automatic deliver(input logic [OUT_W-1:0] s0, input logic [OUT_W-1:0] s1);
        bus.core_out     = {s1, s0};
        bus.core_out_vld = 2'b11;
        bus.core_done    = 1'b1;
        @(negedge clk);
        bus.core_out_vld = 2'b00;
        bus.core_done    = 1'b0;
    endtask

    task automatic expect_result(input logic [OUT_W-1:0] s0, input logic [OUT_W-1:0] s1,
                                 input logic cls);
        int n = 0;
        while (bus.m_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mv_latency", 64'(n), 64'd1);
        check("m_class", 64'(bus.m_class), 64'(cls));
        check("m_scores", 64'(bus.m_scores), 64'({s1, s0}));
    endtask

    task automatic accept(input logic [15:0] exp_cnt);
        bus.m_ready = 1'b1;
        @(negedge clk);
        bus.m_ready = 1'b0;
        check("mv_drop", 64'(bus.m_valid), 64'd0);
        check("frame_cnt", 64'(bus.frame_cnt), 64'(exp_cnt));
        check("s_ready_back", 64'(bus.s_ready), 64'd1);
    endtask

    task automatic frame(input logic [SAMPLE_W-1:0] base, input logic [OUT_W-1:0] s0,
                         input logic [OUT_W-1:0] s1, input logic cls, input logic [15:0] cnt);
        send_frame(base, N_SAMPLES);
        launch(1'b1);
        deliver(s0, s1);
        expect_result(s0, s1, cls);
        accept(cnt);
    endtask

    initial begin
        int n;
        logic [SAMPLE_W-1:0] exp_s;
        bus.s_data = '0; bus.s_valid = 1'b0; bus.core_ready = 1'b0; bus.core_done = 1'b0;
        bus.core_idle = 1'b1; bus.core_out = '0; bus.core_out_vld = '0; bus.m_ready = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_s_ready", 64'(bus.s_ready), 64'd1);
        check("rst_start", 64'(bus.core_start), 64'd0);
        check("rst_in_vld", 64'(bus.core_in_vld), 64'd0);
        check("rst_m_valid", 64'(bus.m_valid), 64'd0);
        check("rst_cnt", 64'(bus.frame_cnt), 64'd0);
        check("rst_tmo", 64'(bus.timeout_err), 64'd0);
        check("rst_core_in", 64'(bus.core_in == '0), 64'd1);
        check("rst_scores", 64'(bus.m_scores), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // 1: samples 0..99 land in order, start lasts one cycle
        send_frame(18'd0, N_SAMPLES);
        launch(1'b1);
        for (int i = 0; i < N_SAMPLES; i++) begin
            check("core_in_i", 64'(bus.core_in[i*SAMPLE_W +: SAMPLE_W]), 64'(i));
        end
        deliver(24'hFFFFFB, 24'h000003);
        expect_result(24'hFFFFFB, 24'h000003, 1'b1);
        accept(16'd1);

        // 2: tie and extreme signed values
        frame(18'h00100, 24'h000007, 24'h000007, 1'b0, 16'd2);
        frame(18'h00200, 24'h800000, 24'h7FFFFF, 1'b1, 16'd3);
        frame(18'h00300, 24'h000010, 24'hFFFFF0, 1'b0, 16'd4);

        // 3: vld[1] three cycles ahead of vld[0]+done
        send_frame(18'h00400, N_SAMPLES);
        launch(1'b1);
        bus.core_out = {24'hFFFF00, 24'h000000};
        bus.core_out_vld = 2'b10;
        @(negedge clk);
        bus.core_out_vld = 2'b00;
        repeat (2) begin
            @(negedge clk);
            check("no_early_mv", 64'(bus.m_valid), 64'd0);
        end
        deliver_split: begin
            bus.core_out = {24'hFFFF00, 24'h000100};
            bus.core_out_vld = 2'b01;
            bus.core_done = 1'b1;
            @(negedge clk);
            bus.core_out_vld = 2'b00;
            bus.core_done = 1'b0;
        end
        expect_result(24'h000100, 24'hFFFF00, 1'b0);
        accept(16'd5);
        @(negedge clk);
        check("single_mv", 64'(bus.m_valid), 64'd0);

        // 4: backpressure holds the result
        send_frame(18'h00500, N_SAMPLES);
        launch(1'b1);
        deliver(24'h000123, 24'h000456);
        expect_result(24'h000123, 24'h000456, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_mv", 64'(bus.m_valid), 64'd1);
            check("hold_scores", 64'(bus.m_scores), 64'({24'h000456, 24'h000123}));
            check("hold_s_ready", 64'(bus.s_ready), 64'd0);
            check("hold_cnt", 64'(bus.frame_cnt), 64'd5);
        end
        accept(16'd6);

        // 5: core never ready -> timeout after TIMEOUT cycles
        send_frame(18'h00600, N_SAMPLES);
        launch(1'b0);
        n = 0;
        while (bus.timeout_err !== 1'b1 && n < TIMEOUT + 100) begin
            @(negedge clk);
            n++;
        end
        check("tmo_cycles", 64'(n), 64'(TIMEOUT));
        check("tmo_err", 64'(bus.timeout_err), 64'd1);
        check("tmo_start", 64'(bus.core_start), 64'd0);
        check("tmo_s_ready", 64'(bus.s_ready), 64'd1);
        check("tmo_cnt", 64'(bus.frame_cnt), 64'd6);
        frame(18'h00700, 24'h000002, 24'h000001, 1'b0, 16'd7);
        check("tmo_sticky", 64'(bus.timeout_err), 64'd1);

        // 6: reset mid-frame, then a clean frame
        send_frame(18'h01000, 50);
        rst = 1'b0;
        @(negedge clk);
        check("mid_s_ready", 64'(bus.s_ready), 64'd1);
        check("mid_start", 64'(bus.core_start), 64'd0);
        check("mid_cnt", 64'(bus.frame_cnt), 64'd0);
        check("mid_tmo", 64'(bus.timeout_err), 64'd0);
        check("mid_core_in", 64'(bus.core_in == '0), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        send_frame(18'h02000, N_SAMPLES);
        launch(1'b1);
        for (int i = 0; i < N_SAMPLES; i += 7) begin
            exp_s = 18'h02000 + SAMPLE_W'(i);
            check("re_core_in", 64'(bus.core_in[i*SAMPLE_W +: SAMPLE_W]), 64'(exp_s));
        end
        deliver(24'hFFFFFE, 24'hFFFFFF);
        expect_result(24'hFFFFFE, 24'hFFFFFF, 1'b1);
        accept(16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
